// File: rtl/sti_dac_pkg.sv
// Shared types and helpers for the serial-transmit / data-arrange controller.
//   length_e  : encoding of the pi_length field selector
//   state_e   : controller FSM states
//   field_len : field length in bits for a given length code and data width
package sti_dac_pkg;

    typedef enum logic [1:0] {
        LEN_HALF   = 2'd0,  // DW/2
        LEN_FULL   = 2'd1,  // DW
        LEN_3HALF  = 2'd2,  // 3*DW/2
        LEN_DOUBLE = 2'd3   // 2*DW
    } length_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_FLUSH,
        S_ZFILL,
        S_DONE
    } state_e;

    function automatic int field_len(input length_e len, input int dw);
        case (len)
            LEN_HALF:  return dw / 2;
            LEN_FULL:  return dw;
            LEN_3HALF: return (3 * dw) / 2;
            default:   return 2 * dw;
        endcase
    endfunction

endpackage

// File: rtl/sti_dac_if.sv
// Word-in / serial-out / pixel-memory-write bundle of sti_dac_pack.
//   master : word source (drives load/pi_*), observes busy, serial and pixel outputs
//   slave  : the controller
interface sti_dac_if #(
    parameter int DW    = 16,
    parameter int PIX_W = 8,
    parameter int AW    = 8
);
    logic             load;
    logic             pi_busy;
    logic [DW-1:0]    pi_data;
    logic [1:0]       pi_length;
    logic             pi_fill;
    logic             pi_msb;
    logic             pi_low;
    logic             pi_end;
    logic             so_data;
    logic             so_valid;
    logic             pixel_wr;
    logic [AW-1:0]    pixel_addr;
    logic [PIX_W-1:0] pixel_dataout;
    logic             pixel_finish;

    modport master (
        output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        input  pi_busy, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
    );

    modport slave (
        input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        output pi_busy, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
    );
endinterface

// File: rtl/sti_dac_pack_pixel_packer.sv
// Packs the serial bit stream into PIX_W-bit pixels (first bit -> MSB) and
// generates the pixel memory write port.
//   clk, reset      : clock, synchronous active-high reset
//   bit_valid/bit_in: one serial bit per cycle
//   flush           : write any partial pixel (including a same-cycle bit) zero-padded
//   zero_wr         : write a zero pixel at the next address
//   pixel_wr/addr/dataout : registered write port
//   next_addr       : address the next write will use
//   top_written     : most recent write went to MEM_DEPTH-1
module sti_dac_pack_pixel_packer
    import sti_dac_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             flush,
    input  logic             zero_wr,
    output logic             pixel_wr,
    output logic [AW-1:0]    pixel_addr,
    output logic [PIX_W-1:0] pixel_dataout,
    output logic [AW-1:0]    next_addr,
    output logic             top_written
);
    localparam int CW = $clog2(PIX_W + 1);

    logic [PIX_W-1:0] sreg_q, sreg_d, shifted, data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [AW-1:0]    addr_q;
    logic             wr_q, wr_d, top_q, top_d;

    // The address advances on the cycle after a write is shown, so the
    // visible pixel_addr always matches the pixel being written.
    assign next_addr = wr_q ? addr_q + 1'b1 : addr_q;

    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        top_d   = top_q;
        shifted = PIX_W'({sreg_q, bit_in});
        cnt_inc = cnt_q + 1'b1;
        if (zero_wr) begin
            wr_d   = 1'b1;
            data_d = '0;
        end else if (bit_valid) begin
            if (cnt_inc == CW'(PIX_W) || flush) begin
                wr_d   = 1'b1;
                data_d = shifted << (CW'(PIX_W) - cnt_inc);
                sreg_d = '0;
                cnt_d  = '0;
            end else begin
                sreg_d = shifted;
                cnt_d  = cnt_inc;
            end
        end else if (flush && cnt_q != '0) begin
            wr_d   = 1'b1;
            data_d = sreg_q << (CW'(PIX_W) - cnt_q);
            sreg_d = '0;
            cnt_d  = '0;
        end
        if (wr_d) top_d = (next_addr == AW'(MEM_DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            wr_q   <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
            top_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            data_q <= data_d;
            addr_q <= next_addr;
            top_q  <= top_d;
        end
    end

    assign pixel_wr      = wr_q;
    assign pixel_addr    = addr_q;
    assign pixel_dataout = data_q;
    assign top_written   = top_q;
endmodule

// File: rtl/sti_dac_pack.sv
// Serial-transmit / data-arrange controller. Formats each accepted word into
// a DW/2..2*DW field, shifts it out on so_*, and packs the same stream into
// PIX_W-bit pixels written to a MEM_DEPTH pixel memory. After an end word the
// partial pixel is flushed and the memory tail zero-filled.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sti_dac_if slave (word input, busy, serial out, pixel write)
module sti_dac_pack
    import sti_dac_pkg::*;
#(
    parameter int DW        = 16,
    parameter int PIX_W     = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic     clk,
    input  logic     reset,
    sti_dac_if.slave bus
);
    localparam int LW = $clog2(2 * DW + 1);

    state_e           state_q, state_d;
    logic [2*DW-1:0]  fld_q, fld_d, fld_in, fld_sh;
    logic [DW-1:0]    dsel;
    logic [LW-1:0]    len_q, len_d, len_in, dw_eff, cnt_q, cnt_d, idx;
    logic             msb_q, msb_d, end_q, end_d, busy_q, busy_d;
    logic             so_data_q, so_data_d, so_valid_q, so_valid_d, finish_q, finish_d;
    logic             flush, zero_wr, top_written;
    logic [AW-1:0]    next_addr;

    // Field formatter: field sits in fld[L-1:0]; MSB alignment shifts the
    // data up by (L - data width), zero-padding the low end.
    always_comb begin
        len_in = LW'(field_len(length_e'(bus.pi_length), DW));
        dsel   = bus.pi_data;
        dw_eff = LW'(DW);
        if (length_e'(bus.pi_length) == LEN_HALF) begin
            dw_eff = LW'(DW / 2);
            dsel   = bus.pi_low ? {{(DW/2){1'b0}}, bus.pi_data[DW/2-1:0]}
                                : {{(DW/2){1'b0}}, bus.pi_data[DW-1:DW/2]};
        end
        fld_in = {{DW{1'b0}}, dsel};
        if (bus.pi_fill) fld_in = fld_in << (len_in - dw_eff);
    end

    assign idx    = msb_q ? (len_q - 1'b1 - cnt_q) : cnt_q;
    assign fld_sh = fld_q >> idx;

    always_comb begin
        state_d    = state_q;
        fld_d      = fld_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        msb_d      = msb_q;
        end_d      = end_q;
        busy_d     = busy_q;
        so_data_d  = 1'b0;
        so_valid_d = 1'b0;
        finish_d   = finish_q;
        flush      = 1'b0;
        zero_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // busy stays high for one IDLE cycle after a word, giving the
                // mandatory idle gap between back-to-back words.
                if (bus.load && !busy_q) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    fld_d   = fld_in;
                    len_d   = len_in;
                    msb_d   = bus.pi_msb;
                    end_d   = bus.pi_end;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end
            S_SHIFT: begin
                so_valid_d = 1'b1;
                so_data_d  = fld_sh[0];
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == len_q - 1'b1) state_d = end_q ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                // The packer absorbs the final serial bit on this same cycle.
                flush   = 1'b1;
                state_d = S_ZFILL;
            end
            S_ZFILL: begin
                if (top_written) begin
                    state_d = S_DONE;
                end else begin
                    zero_wr = 1'b1;
                    if (next_addr == AW'(MEM_DEPTH - 1)) state_d = S_DONE;
                end
            end
            S_DONE:  finish_d = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fld_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            msb_q      <= 1'b0;
            end_q      <= 1'b0;
            busy_q     <= 1'b0;
            so_data_q  <= 1'b0;
            so_valid_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fld_q      <= fld_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            msb_q      <= msb_d;
            end_q      <= end_d;
            busy_q     <= busy_d;
            so_data_q  <= so_data_d;
            so_valid_q <= so_valid_d;
            finish_q   <= finish_d;
        end
    end

    sti_dac_pack_pixel_packer #(
        .PIX_W     (PIX_W),
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_packer (
        .clk           (clk),
        .reset         (reset),
        .bit_valid     (so_valid_q),
        .bit_in        (so_data_q),
        .flush         (flush),
        .zero_wr       (zero_wr),
        .pixel_wr      (bus.pixel_wr),
        .pixel_addr    (bus.pixel_addr),
        .pixel_dataout (bus.pixel_dataout),
        .next_addr     (next_addr),
        .top_written   (top_written)
    );

    assign bus.pi_busy      = busy_q;
    assign bus.so_data      = so_data_q;
    assign bus.so_valid     = so_valid_q;
    assign bus.pixel_finish = finish_q;
endmodule
